// File: rtl/ip_header_extract_pkg.sv
// Shared IPv4 header field positions and protocol numbers for the header extract/update stages.
// FSM state type for the header extractor.
package ip_header_extract_pkg;

  localparam int unsigned HdrBits   = 160;
  localparam int unsigned VerMsb    = 159;
  localparam int unsigned IhlMsb    = 155;
  localparam int unsigned TlenMsb   = 143;
  localparam int unsigned MfBit     = 109;
  localparam int unsigned OffsetMsb = 108;
  localparam int unsigned ProtoMsb  = 87;
  localparam int unsigned CsumMsb   = 79;

  localparam logic [7:0]  ProtoTcp    = 8'd6;
  localparam logic [7:0]  ProtoUdp    = 8'd17;
  localparam logic [3:0]  Ipv4Version = 4'd4;
  localparam logic [3:0]  MinIhl      = 4'd5;
  localparam logic [15:0] MinTlen     = 16'd20;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StHand,
    StWait,
    StPay
  } state_e;

endpackage

// File: rtl/ip_csum_acc.sv
// IPv4 header checksum accumulator: sums 16-bit halves of each header word into 20 bits,
// folds the carries back in and flags a valid one's-complement sum.
module ip_csum_acc (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        add,
  input  logic [31:0] word,
  output logic        ok
);

  logic [19:0] acc_q, acc_d, word_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign word_sum = {4'd0, word[31:16]} + {4'd0, word[15:0]};

  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = word_sum;
    end else if (add) begin
      acc_d = acc_q + word_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Five words never exceed 20 bits, so two folds always leave a clean 16-bit sum.
  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign ok    = (fold2 == 16'hFFFF);

endmodule

// File: rtl/ip_header_extract.sv
// Assembles the 20-byte IPv4 header from a 32-bit stream, checks it, classifies encrypt/bypass,
// hands the header over and then passes the payload through with backpressure.
module ip_header_extract
  import ip_header_extract_pkg::*;
#(
  parameter logic       ENCRYPT_ALL = 1'b0,
  parameter logic [7:0] PROTO_TCP   = ProtoTcp,
  parameter logic [7:0] PROTO_UDP   = ProtoUdp
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        din,
  input  logic               din_valid,
  input  logic               din_sop,
  input  logic               din_eop,
  output logic               din_ready,
  output logic [HdrBits-1:0] header,
  output logic               direct,
  output logic               ready,
  input  logic               done,
  output logic [31:0]        pay_data,
  output logic               pay_valid,
  output logic               pay_last,
  input  logic               pay_ready,
  output logic               csum_err,
  output logic               runt_err
);

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic [HdrBits-1:0] header_q;
  logic               last_eop_q, ready_q, direct_q, csum_err_q, runt_err_q;
  logic               xfer, start, csum_add, csum_ok, direct_calc, pay_state;
  logic [7:0]         proto;

  always_comb begin
    din_ready = 1'b0;
    if (reset) begin
      unique case (state_q)
        StIdle, StHdr: din_ready = 1'b1;
        StPay:         din_ready = pay_ready;
        default:       din_ready = 1'b0;
      endcase
    end
  end

  assign xfer     = din_valid & din_ready;
  assign start    = xfer & din_sop;
  assign csum_add = xfer & ~din_sop & (state_q == StHdr);

  ip_csum_acc u_csum (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .add   (csum_add),
    .word  (din),
    .ok    (csum_ok)
  );

  assign proto       = header_q[ProtoMsb -: 8];
  assign direct_calc = (header_q[VerMsb -: 4] != Ipv4Version) |
                       (header_q[IhlMsb -: 4] != MinIhl) |
                       (header_q[TlenMsb -: 16] < MinTlen) |
                       ~csum_ok |
                       (~ENCRYPT_ALL & (proto != PROTO_TCP) & (proto != PROTO_UDP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      header_q   <= '0;
      last_eop_q <= 1'b0;
      ready_q    <= 1'b0;
      direct_q   <= 1'b0;
      csum_err_q <= 1'b0;
      runt_err_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      csum_err_q <= 1'b0;
      runt_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            header_q[159:128] <= din;
            cnt_q             <= 3'd1;
            if (din_eop) begin
              runt_err_q <= 1'b1;
            end else begin
              state_q <= StHdr;
            end
          end
        end
        StHdr: begin
          if (start) begin
            // A new sop mid-header abandons the old header and restarts with this word.
            runt_err_q        <= 1'b1;
            header_q[159:128] <= din;
            cnt_q             <= 3'd1;
            if (din_eop) begin
              state_q <= StIdle;
            end
          end else if (xfer) begin
            unique case (cnt_q)
              3'd1:    header_q[127:96] <= din;
              3'd2:    header_q[95:64]  <= din;
              3'd3:    header_q[63:32]  <= din;
              3'd4:    header_q[31:0]   <= din;
              default: ;
            endcase
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
              last_eop_q <= din_eop;
              state_q    <= StHand;
            end else if (din_eop) begin
              runt_err_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end
        StHand: begin
          ready_q    <= 1'b1;
          direct_q   <= direct_calc;
          csum_err_q <= ~csum_ok;
          state_q    <= StWait;
        end
        StWait: begin
          if (done) begin
            state_q <= last_eop_q ? StIdle : StPay;
          end
        end
        StPay: begin
          if (start) begin
            // sop ends the previous packet implicitly; this word is word0 of the next one.
            header_q[159:128] <= din;
            cnt_q             <= 3'd1;
            if (din_eop) begin
              runt_err_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              state_q <= StHdr;
            end
          end else if (xfer && din_eop) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pay_state = (state_q == StPay);
  assign pay_valid = pay_state & din_valid & ~din_sop;
  assign pay_last  = pay_valid & din_eop;
  assign pay_data  = pay_state ? din : '0;

  assign header   = header_q;
  assign direct   = direct_q;
  assign ready    = ready_q;
  assign csum_err = csum_err_q;
  assign runt_err = runt_err_q;

endmodule

// File: tb/tb_ip_header_extract.sv
// Scoreboard bench for ip_header_extract: random IPv4 packets against a field-level model, two
// instances (ENCRYPT_ALL 0 and 1) sharing stimulus.
module tb_ip_header_extract;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic         done = 1'b0, pay_ready = 1'b1;

  logic         din_ready0, direct0, ready0, pay_valid0, pay_last0, csum_err0, runt_err0;
  logic [159:0] header0;
  logic [31:0]  pay_data0;
  logic         din_ready1, direct1, ready1, pay_valid1, pay_last1, csum_err1, runt_err1;
  logic [159:0] header1;
  logic [31:0]  pay_data1;

  always #5 clk = ~clk;

  ip_header_extract #(.ENCRYPT_ALL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .din_eop(din_eop), .din_ready(din_ready0), .header(header0), .direct(direct0),
    .ready(ready0), .done(done), .pay_data(pay_data0), .pay_valid(pay_valid0),
    .pay_last(pay_last0), .pay_ready(pay_ready), .csum_err(csum_err0), .runt_err(runt_err0)
  );

  ip_header_extract #(.ENCRYPT_ALL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .din_eop(din_eop), .din_ready(din_ready1), .header(header1), .direct(direct1),
    .ready(ready1), .done(done), .pay_data(pay_data1), .pay_valid(pay_valid1),
    .pay_last(pay_last1), .pay_ready(pay_ready), .csum_err(csum_err1), .runt_err(runt_err1)
  );

  typedef struct {
    logic [159:0] hdr;
    logic         direct;
    logic         csum_err;
  } hdr_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } pay_exp_t;

  hdr_exp_t hdr0_q[$];
  hdr_exp_t hdr1_q[$];
  pay_exp_t pay_q[$];
  int checks = 0, failures = 0, runt_exp = 0, runt_seen = 0;
  int done_delay = -1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // One's-complement sum of the ten header halfwords, carries folded until none remain.
  function automatic logic [15:0] ones_sum(input logic [159:0] h);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 10; i++) s += 32'(h[i*16 +: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  task automatic drive_word(input logic [31:0] w, input logic sop, input logic eop);
    int budget;
    bit acc;
    budget = 300;
    acc = 1'b0;
    repeat ($urandom_range(0, 1)) begin
      din_valid = 1'b0;
      @(posedge clk); #1;
    end
    din = w; din_sop = sop; din_eop = eop; din_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = din_ready0;
      @(posedge clk); #1;
      budget--;
      if (!acc && budget == 0) begin
        unexpected("din_accept_timeout");
        acc = 1'b1;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tlen,
                             input logic [7:0] proto, input bit bad_csum, input int npay,
                             input bit with_eop, input int runt_at);
    logic [159:0] h;
    logic [31:0]  words[$];
    hdr_exp_t     e;
    pay_exp_t     p;
    bit           ok, base_bad;
    int           last_idx;
    h = {ver, ihl, 8'h00, tlen, 16'($urandom), 16'h4000, 8'd64, proto, 16'h0000,
         32'($urandom), 32'($urandom)};
    h[79:64] = ~ones_sum(h) + 16'(bad_csum);
    for (int i = 0; i < 5; i++) words.push_back(h[159 - 32*i -: 32]);
    for (int i = 0; i < npay; i++) words.push_back(32'($urandom));
    if (runt_at >= 0) begin
      runt_exp++;
      for (int i = 0; i <= runt_at; i++) drive_word(words[i], i == 0, i == runt_at);
    end else begin
      ok = (ones_sum(h) == 16'hFFFF);
      base_bad = (ver != 4'd4) || (ihl != 4'd5) || (tlen < 16'd20) || !ok;
      e.hdr = h;
      e.csum_err = !ok;
      e.direct = base_bad || !(proto == 8'd6 || proto == 8'd17);
      hdr0_q.push_back(e);
      e.direct = base_bad;
      hdr1_q.push_back(e);
      for (int i = 0; i < npay; i++) begin
        p.data = words[5 + i];
        p.last = with_eop && (i == npay - 1);
        pay_q.push_back(p);
      end
      last_idx = words.size() - 1;
      for (int i = 0; i <= last_idx; i++) drive_word(words[i], i == 0, with_eop && i == last_idx);
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present a header or a payload transfer.
  always @(negedge clk) begin
    hdr_exp_t e;
    pay_exp_t p;
    if (reset) begin
      if (ready0) begin
        if (hdr0_q.size() == 0) unexpected("ready0_extra");
        else begin
          e = hdr0_q.pop_front();
          check("header0", header0, e.hdr);
          check("direct0", direct0, e.direct);
          check("csum_err", csum_err0, e.csum_err);
        end
      end else if (csum_err0) unexpected("csum_err_without_ready");
      if (ready1) begin
        if (hdr1_q.size() == 0) unexpected("ready1_extra");
        else begin
          e = hdr1_q.pop_front();
          check("header1", header1, e.hdr);
          check("direct1_encrypt_all", direct1, e.direct);
        end
      end
      if (runt_err0) runt_seen++;
      if (pay_valid0 && pay_ready) begin
        if (pay_q.size() == 0) unexpected("pay_extra");
        else begin
          p = pay_q.pop_front();
          check("pay_data", pay_data0, p.data);
          check("pay_last", pay_last0, p.last);
        end
      end
    end
  end

  // Header consumer: answers each ready with done after a delay, checking the hold meanwhile.
  initial begin
    logic [159:0] held;
    logic         held_dir;
    bit           stable;
    int           d;
    forever begin
      @(negedge clk);
      if (reset && ready0) begin
        held = header0;
        held_dir = direct0;
        stable = 1'b1;
        d = (done_delay >= 0) ? done_delay : int'($urandom_range(0, 3));
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (din_ready0 || header0 !== held || direct0 !== held_dir) stable = 1'b0;
        end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        check("wait_hold_stable", stable, 1'b1);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pay_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    unexpected("watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [3:0] ver, ihl;
    logic [15:0] tlen;
    logic [7:0] proto;
    repeat (3) @(posedge clk);
    #1;
    check("rst_header", header0, '0);
    check("rst_ready_direct", {ready0, direct0}, 2'b00);
    check("rst_errs", {csum_err0, runt_err0}, 2'b00);
    check("rst_pay", {pay_valid0, pay_last0, din_ready0}, 3'b000);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    send_packet(4'd4, 4'd5, 16'd36, 8'd17, 1'b0, 4, 1'b1, -1);   // UDP, clean
    send_packet(4'd4, 4'd5, 16'd36, 8'd17, 1'b1, 4, 1'b1, -1);   // bad checksum
    send_packet(4'd4, 4'd5, 16'd28, 8'd1, 1'b0, 2, 1'b1, -1);    // ICMP
    send_packet(4'd4, 4'd5, 16'd40, 8'd6, 1'b0, 3, 1'b1, 2);     // runt: eop on word2
    send_packet(4'd4, 4'd5, 16'd40, 8'd6, 1'b0, 3, 1'b1, -1);
    done_delay = 10;
    send_packet(4'd4, 4'd5, 16'd36, 8'd17, 1'b0, 4, 1'b1, -1);
    done_delay = -1;
    send_packet(4'd4, 4'd6, 16'd44, 8'd17, 1'b0, 3, 1'b1, -1);   // options, bypassed
    send_packet(4'd6, 4'd5, 16'd40, 8'd6, 1'b0, 1, 1'b1, -1);    // wrong version
    send_packet(4'd4, 4'd5, 16'd10, 8'd6, 1'b0, 1, 1'b1, -1);    // short total length
    send_packet(4'd4, 4'd5, 16'd20, 8'd6, 1'b0, 0, 1'b1, -1);    // header only
    send_packet(4'd4, 4'd5, 16'd32, 8'd17, 1'b0, 2, 1'b0, -1);   // no eop; next sop ends it
    send_packet(4'd4, 4'd5, 16'd32, 8'd6, 1'b0, 2, 1'b1, -1);

    // Reset in PAY with a payload word presented.
    send_packet(4'd4, 4'd5, 16'd60, 8'd17, 1'b0, 2, 1'b0, -1);
    din = 32'hA5A5_5A5A; din_sop = 1'b0; din_eop = 1'b0; din_valid = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rstpay_header", header0, '0);
    check("rstpay_ready", ready0, 1'b0);
    check("rstpay_pay_valid", pay_valid0, 1'b0);
    check("rstpay_pay_data", pay_data0, 32'd0);
    check("rstpay_din_ready", din_ready0, 1'b0);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    send_packet(4'd4, 4'd5, 16'd36, 8'd17, 1'b0, 4, 1'b1, -1);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) drive_word(32'($urandom), 1'b0, 1'b0);  // discarded in IDLE
      ver   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd4;
      ihl   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 7)) : 4'd5;
      tlen  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 19)) : 16'($urandom_range(20, 1500));
      case ($urandom_range(0, 3))
        0: proto = 8'd6;
        1: proto = 8'd17;
        2: proto = 8'd1;
        default: proto = 8'($urandom);
      endcase
      send_packet(ver, ihl, tlen, proto, $urandom_range(0, 5) == 0, int'($urandom_range(0, 5)),
                  1'b1, ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    repeat (20) @(posedge clk);
    #1;
    check("hdr0_drained", 32'(hdr0_q.size()), 32'd0);
    check("hdr1_drained", 32'(hdr1_q.size()), 32'd0);
    check("pay_drained", 32'(pay_q.size()), 32'd0);
    check("runt_count", 32'(runt_seen), 32'(runt_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
